// File: rtl/dpdm_decode.sv
// USB receive-side line decoder: SYNC hunt, NRZI decode, bit unstuffing,
// PID classification and EOP checking.
`timescale 1ns/1ps
module dpdm_decode (
    input  logic clock,
    input  logic reset,
    input  logic DP_in,
    input  logic DM_in,
    input  logic rec_start,
    output logic out_bit,
    output logic dpdm_sending,
    output logic ACK_rec,
    output logic NAK_rec,
    output logic DATA0_rec,
    output logic rec_error
);

    typedef enum logic [1:0] {StIdle, StWaitSync, StRecv, StEop} state_t;

    state_t      r_state;
    logic        r_prev;      // previous line level, 1 = J
    logic [7:0]  r_hist;      // last J/K line states, newest in bit 0 (1 = J)
    logic [2:0]  r_ones;
    logic [3:0]  r_cnt;
    logic [7:0]  r_pid;
    logic        r_eop_se0;
    logic        r_out_bit;
    logic        r_sending;
    logic        r_ack;
    logic        r_nak;
    logic        r_data0;
    logic        r_err;

    logic        w_j;
    logic        w_k;
    logic        w_se0;
    logic        w_jk;
    logic        w_bit;
    logic [7:0]  w_hist;
    logic [7:0]  w_pid;

    assign w_j    = DP_in & ~DM_in;
    assign w_k    = ~DP_in & DM_in;
    assign w_se0  = ~DP_in & ~DM_in;
    assign w_jk   = w_j | w_k;
    assign w_bit  = (DP_in == r_prev);
    assign w_hist = {r_hist[6:0], DP_in};
    assign w_pid  = {w_bit, r_pid[7:1]};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= StIdle;
            r_prev    <= 1'b1;
            r_hist    <= 8'hFF;
            r_ones    <= 3'd0;
            r_cnt     <= 4'd0;
            r_pid     <= 8'h00;
            r_eop_se0 <= 1'b0;
            r_out_bit <= 1'b0;
            r_sending <= 1'b0;
            r_ack     <= 1'b0;
            r_nak     <= 1'b0;
            r_data0   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_out_bit <= 1'b0;
            r_sending <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (rec_start) begin
                        r_ack   <= 1'b0;
                        r_nak   <= 1'b0;
                        r_data0 <= 1'b0;
                        r_err   <= 1'b0;
                        r_prev  <= 1'b1;
                        r_hist  <= 8'hFF;
                        r_state <= StWaitSync;
                    end
                end
                StWaitSync: begin
                    if (w_jk) begin
                        r_hist <= w_hist;
                        r_prev <= DP_in;
                        // K,J,K,J,K,J,K,K oldest first
                        if (w_hist == 8'h54) begin
                            r_ones  <= 3'd0;
                            r_cnt   <= 4'd0;
                            r_state <= StRecv;
                        end
                    end
                end
                StRecv: begin
                    if (w_jk) begin
                        r_prev <= DP_in;
                        if (r_ones == 3'd6) begin
                            r_ones <= 3'd0;
                            if (w_bit) begin
                                r_err   <= 1'b1;
                                r_state <= StIdle;
                            end
                        end else begin
                            r_out_bit <= w_bit;
                            r_sending <= 1'b1;
                            r_ones    <= w_bit ? r_ones + 3'd1 : 3'd0;
                            if (r_cnt < 4'd8) begin
                                r_cnt <= r_cnt + 4'd1;
                                r_pid <= w_pid;
                            end
                            if (r_cnt == 4'd7) begin
                                if (w_pid[3:0] != ~w_pid[7:4]) begin
                                    r_err <= 1'b1;
                                end else begin
                                    r_ack   <= (w_pid == 8'hD2);
                                    r_nak   <= (w_pid == 8'h5A);
                                    r_data0 <= (w_pid == 8'hC3);
                                end
                            end
                        end
                    end else if (w_se0) begin
                        r_eop_se0 <= 1'b0;
                        r_state   <= StEop;
                        if (r_cnt < 4'd8) begin
                            r_err <= 1'b1;
                        end
                    end else begin
                        r_err   <= 1'b1;
                        r_state <= StIdle;
                    end
                end
                StEop: begin
                    if (!r_eop_se0) begin
                        if (w_se0) begin
                            r_eop_se0 <= 1'b1;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= StIdle;
                        end
                    end else begin
                        if (!w_j) begin
                            r_err <= 1'b1;
                        end
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign out_bit      = r_out_bit;
    assign dpdm_sending = r_sending;
    assign ACK_rec      = r_ack;
    assign NAK_rec      = r_nak;
    assign DATA0_rec    = r_data0;
    assign rec_error    = r_err;

endmodule

// File: tb/tb_dpdm_decode.sv
// Directed bench for dpdm_decode: packets, stuffing, PID errors, EOP errors, reset.
`timescale 1ns/1ps
module tb_dpdm_decode;

    logic clock = 1'b0;
    logic reset;
    logic DP_in;
    logic DM_in;
    logic rec_start;
    logic out_bit;
    logic dpdm_sending;
    logic ACK_rec;
    logic NAK_rec;
    logic DATA0_rec;
    logic rec_error;

    int vectors     = 0;
    int miscompares = 0;

    dpdm_decode u_dut (
        .clock        (clock),
        .reset        (reset),
        .DP_in        (DP_in),
        .DM_in        (DM_in),
        .rec_start    (rec_start),
        .out_bit      (out_bit),
        .dpdm_sending (dpdm_sending),
        .ACK_rec      (ACK_rec),
        .NAK_rec      (NAK_rec),
        .DATA0_rec    (DATA0_rec),
        .rec_error    (rec_error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive one line state, let the DUT sample it, then look at the result.
    task automatic step(input logic dp, input logic dm);
        DP_in = dp;
        DM_in = dm;
        @(posedge clock);
        #1;
    endtask

    // Bit i of dp is the D+ level at time i (J/K only); send/bits give expectations.
    task automatic jk_seq(input string tag, input logic [15:0] dp, input int n,
                          input logic [15:0] bits, input logic [15:0] send);
        for (int i = 0; i < n; i++) begin
            step(dp[i], ~dp[i]);
            chk($sformatf("%s_send%0d", tag, i), dpdm_sending, send[i]);
            if (send[i]) chk($sformatf("%s_bit%0d", tag, i), out_bit, bits[i]);
        end
    endtask

    task automatic flags(input string tag, input logic a, input logic n, input logic d,
                         input logic e);
        chk({tag, "_ack"}, ACK_rec, a);
        chk({tag, "_nak"}, NAK_rec, n);
        chk({tag, "_data0"}, DATA0_rec, d);
        chk({tag, "_err"}, rec_error, e);
    endtask

    task automatic arm();
        rec_start = 1'b1;
        step(1'b1, 1'b0);
        rec_start = 1'b0;
        chk("arm_send", dpdm_sending, 1'b0);
        chk("arm_err_clr", rec_error, 1'b0);
    endtask

    // K,J,K,J,K,J,K,K
    task automatic sync(input string tag);
        jk_seq(tag, 16'h002A, 8, 16'h0000, 16'h0000);
    endtask

    task automatic eop(input string tag);
        step(1'b0, 1'b0);
        chk({tag, "_eop0"}, dpdm_sending, 1'b0);
        step(1'b0, 1'b0);
        chk({tag, "_eop1"}, dpdm_sending, 1'b0);
        step(1'b1, 1'b0);
        chk({tag, "_eop2"}, dpdm_sending, 1'b0);
    endtask

    initial begin
        reset     = 1'b1;
        rec_start = 1'b0;
        DP_in     = 1'b1;
        DM_in     = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_send", dpdm_sending, 1'b0);
        chk("rst_bit", out_bit, 1'b0);
        flags("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // SYNC and a NAK PID on the line without rec_start: ignored
        sync("norx_sync");
        jk_seq("norx_pid", 16'h0063, 8, 16'h0000, 16'h0000);
        eop("norx");
        flags("norx", 1'b0, 1'b0, 1'b0, 1'b0);

        // NAK 0x5A
        arm();
        sync("nak_sync");
        jk_seq("nak", 16'h0063, 8, 16'h005A, 16'h00FF);
        flags("nak", 1'b0, 1'b1, 1'b0, 1'b0);
        eop("nak");
        flags("nak_end", 1'b0, 1'b1, 1'b0, 1'b0);

        // ACK 0xD2, back to back; previous NAK flag must be cleared
        arm();
        sync("ack_sync");
        jk_seq("ack", 16'h001B, 8, 16'h00D2, 16'h00FF);
        flags("ack", 1'b1, 1'b0, 1'b0, 1'b0);
        eop("ack");
        flags("ack_end", 1'b1, 1'b0, 1'b0, 1'b0);

        // DATA0 0xC3 plus payload K,K,K,J,J,J -> 1,1,1,0,1,1
        arm();
        sync("d0_sync");
        jk_seq("d0pid", 16'h0014, 8, 16'h00C3, 16'h00FF);
        flags("d0", 1'b0, 1'b0, 1'b1, 1'b0);
        jk_seq("d0pay", 16'h0038, 6, 16'h0037, 16'h003F);
        eop("d0");
        flags("d0_end", 1'b0, 1'b0, 1'b1, 1'b0);

        // Six 1s then a transition: stuffed 0 dropped, reception continues
        arm();
        sync("stfb_sync");
        jk_seq("stfb_pid", 16'h0063, 8, 16'h005A, 16'h00FF);
        jk_seq("stfb_ones", 16'h0000, 6, 16'h003F, 16'h003F);
        jk_seq("stfb_drop", 16'h0003, 2, 16'h0002, 16'h0002);
        chk("stfb_err_mid", rec_error, 1'b0);
        eop("stfb");
        flags("stfb_end", 1'b0, 1'b1, 1'b0, 1'b0);

        // Seven equal levels: stuff error
        arm();
        sync("stfa_sync");
        jk_seq("stfa_pid", 16'h0063, 8, 16'h005A, 16'h00FF);
        jk_seq("stfa_ones", 16'h0000, 6, 16'h003F, 16'h003F);
        step(1'b0, 1'b1);
        chk("stfa_send7", dpdm_sending, 1'b0);
        flags("stfa", 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1);
        chk("stfa_idle_send", dpdm_sending, 1'b0);
        step(1'b1, 1'b0);

        // Corrupted PID 0x5B: strobes, error, no PID flag
        arm();
        sync("bad_sync");
        jk_seq("bad", 16'h009C, 8, 16'h005B, 16'h00FF);
        flags("bad", 1'b0, 1'b0, 1'b0, 1'b1);
        eop("bad");
        flags("bad_end", 1'b0, 1'b0, 1'b0, 1'b1);

        // SE0,J right after SYNC
        arm();
        sync("se0_sync");
        step(1'b0, 1'b0);
        chk("se0_send", dpdm_sending, 1'b0);
        chk("se0_err", rec_error, 1'b1);
        step(1'b1, 1'b0);
        flags("se0_end", 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of a NAK PID
        arm();
        sync("rpid_sync");
        jk_seq("rpid", 16'h0063, 4, 16'h000A, 16'h000F);
        reset = 1'b1;
        step(1'b0, 1'b1);
        chk("rpid_send", dpdm_sending, 1'b0);
        chk("rpid_bit", out_bit, 1'b0);
        flags("rpid", 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        jk_seq("rpid_idle", 16'h0003, 4, 16'h0000, 16'h0000);
        flags("rpid_idle", 1'b0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
